// File: rtl/time_of_day_counter.sv
// Time-of-day counter: prescaled seconds/minutes/hours with synchronous set,
// registered BCD display in 12 h or 24 h format, AM/PM and second/day pulses.
`timescale 1ns/1ps
module time_of_day_counter #(
    parameter int unsigned CLK_DIV = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       set_en,
    input  logic [4:0] set_hour,
    input  logic [5:0] set_min,
    input  logic       mode_24h,
    output logic [1:0] hr_tens,
    output logic [3:0] hr_ones,
    output logic [2:0] min_tens,
    output logic [3:0] min_ones,
    output logic [2:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       pm,
    output logic       sec_pulse,
    output logic       day_pulse
);

    localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(CLK_DIV - 1);

    logic [PW-1:0] prescaler;
    logic [5:0]    sec_cnt;
    logic [5:0]    min_cnt;
    logic [4:0]    hour_cnt;
    logic          tick_q;
    logic          day_q;

    logic          tick_c;
    logic          day_wrap_c;
    logic [4:0]    disp_hour_c;
    logic [1:0]    hr_tens_c;
    logic [2:0]    min_tens_c;
    logic [2:0]    sec_tens_c;

    // Tens digit of a 0..59 value by range compare
    function automatic logic [2:0] tens_59(input logic [5:0] v);
        logic [2:0] t;
        if (v >= 6'd50)      t = 3'd5;
        else if (v >= 6'd40) t = 3'd4;
        else if (v >= 6'd30) t = 3'd3;
        else if (v >= 6'd20) t = 3'd2;
        else if (v >= 6'd10) t = 3'd1;
        else                 t = 3'd0;
        return t;
    endfunction

    // Ones digit of a 0..59 value given its tens digit
    function automatic logic [3:0] ones_59(input logic [5:0] v, input logic [2:0] t);
        logic [5:0] r;
        r = v - (6'(t) * 6'd10);
        return 4'(r);
    endfunction

    // Tens digit of a 0..23 value by range compare
    function automatic logic [1:0] tens_23(input logic [4:0] v);
        logic [1:0] t;
        if (v >= 5'd20)      t = 2'd2;
        else if (v >= 5'd10) t = 2'd1;
        else                 t = 2'd0;
        return t;
    endfunction

    // Ones digit of a 0..23 value given its tens digit
    function automatic logic [3:0] ones_23(input logic [4:0] v, input logic [1:0] t);
        logic [4:0] r;
        r = v - (5'(t) * 5'd10);
        return 4'(r);
    endfunction

    assign tick_c     = run & (prescaler == PMAX);
    assign day_wrap_c = (sec_cnt == 6'd59) & (min_cnt == 6'd59) & (hour_cnt == 5'd23);

    // Core time state: set load has priority over a coincident tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
            sec_cnt   <= '0;
            min_cnt   <= '0;
            hour_cnt  <= '0;
            tick_q    <= 1'b0;
            day_q     <= 1'b0;
        end else if (set_en) begin
            prescaler <= '0;
            sec_cnt   <= '0;
            min_cnt   <= (set_min > 6'd59) ? 6'd59 : set_min;
            hour_cnt  <= (set_hour > 5'd23) ? 5'd23 : set_hour;
            tick_q    <= 1'b0;
            day_q     <= 1'b0;
        end else begin
            tick_q <= tick_c;
            day_q  <= tick_c & day_wrap_c;
            if (tick_c) begin
                prescaler <= '0;
                if (sec_cnt == 6'd59) begin
                    sec_cnt <= '0;
                    if (min_cnt == 6'd59) begin
                        min_cnt <= '0;
                        if (hour_cnt == 5'd23) hour_cnt <= '0;
                        else                   hour_cnt <= hour_cnt + 5'd1;
                    end else begin
                        min_cnt <= min_cnt + 6'd1;
                    end
                end else begin
                    sec_cnt <= sec_cnt + 6'd1;
                end
            end else if (run) begin
                prescaler <= prescaler + PW'(1);
            end
        end
    end

    // Hour shown on the display: 24 h passthrough or 12 h mapping (0 -> 12)
    always_comb begin
        disp_hour_c = hour_cnt;
        if (!mode_24h) begin
            if (hour_cnt == 5'd0)       disp_hour_c = 5'd12;
            else if (hour_cnt > 5'd12)  disp_hour_c = hour_cnt - 5'd12;
        end
    end

    assign hr_tens_c  = tens_23(disp_hour_c);
    assign min_tens_c = tens_59(min_cnt);
    assign sec_tens_c = tens_59(sec_cnt);

    // Format stage: digits and pulses registered together so they line up
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hr_tens   <= '0;
            hr_ones   <= '0;
            min_tens  <= '0;
            min_ones  <= '0;
            sec_tens  <= '0;
            sec_ones  <= '0;
            pm        <= 1'b0;
            sec_pulse <= 1'b0;
            day_pulse <= 1'b0;
        end else begin
            hr_tens   <= hr_tens_c;
            hr_ones   <= ones_23(disp_hour_c, hr_tens_c);
            min_tens  <= min_tens_c;
            min_ones  <= ones_59(min_cnt, min_tens_c);
            sec_tens  <= sec_tens_c;
            sec_ones  <= ones_59(sec_cnt, sec_tens_c);
            pm        <= (hour_cnt >= 5'd12);
            sec_pulse <= tick_q;
            day_pulse <= day_q;
        end
    end

endmodule

// File: tb/tb_time_of_day_counter.sv
// Scoreboard bench for time_of_day_counter with a 4-cycle prescaler.
`timescale 1ns/1ps
module tb_time_of_day_counter;

    localparam int unsigned DIV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       set_en;
    logic [4:0] set_hour;
    logic [5:0] set_min;
    logic       mode_24h;
    logic [1:0] hr_tens;
    logic [3:0] hr_ones;
    logic [2:0] min_tens;
    logic [3:0] min_ones;
    logic [2:0] sec_tens;
    logic [3:0] sec_ones;
    logic       pm;
    logic       sec_pulse;
    logic       day_pulse;

    typedef struct {
        string      name;
        int         cyc;
        logic [1:0] ht;
        logic [3:0] ho;
        logic [2:0] mt;
        logic [3:0] mo;
        logic [2:0] st;
        logic [3:0] so;
        logic       pm;
        logic       sp;
        logic       dp;
    } exp_t;

    exp_t pulse_q[$];
    exp_t probe_q[$];
    exp_t mon_e;
    exp_t prb_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   base = 0;
    event probe_ev;

    time_of_day_counter #(.CLK_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .run(run), .set_en(set_en),
        .set_hour(set_hour), .set_min(set_min), .mode_24h(mode_24h),
        .hr_tens(hr_tens), .hr_ones(hr_ones), .min_tens(min_tens),
        .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
        .pm(pm), .sec_pulse(sec_pulse), .day_pulse(day_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected display for a given time of day and format
    function automatic exp_t mk(input string name, input int h, input int m, input int s,
                                input logic mode, input logic sp, input logic dp, input int c);
        exp_t e;
        int   dh;
        dh     = mode ? h : (((h % 12) == 0) ? 12 : (h % 12));
        e.name = name;
        e.cyc  = c;
        e.ht   = 2'(dh / 10);
        e.ho   = 4'(dh % 10);
        e.mt   = 3'(m / 10);
        e.mo   = 4'(m % 10);
        e.st   = 3'(s / 10);
        e.so   = 4'(s % 10);
        e.pm   = (h >= 12);
        e.sp   = sp;
        e.dp   = dp;
        return e;
    endfunction

    task automatic compare(input exp_t e, input bit use_cyc);
        logic [22:0] got;
        logic [22:0] want;
        got  = {hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones, pm, sec_pulse, day_pulse};
        want = {e.ht, e.ho, e.mt, e.mo, e.st, e.so, e.pm, e.sp, e.dp};
        checks++;
        if (got !== want || (use_cyc && cyc != e.cyc)) begin
            errors++;
            $display("FAIL %s got cyc=%0d %0d%0d:%0d%0d:%0d%0d pm=%0b sp=%0b dp=%0b want cyc=%0d %0d%0d:%0d%0d:%0d%0d pm=%0b sp=%0b dp=%0b",
                     e.name, cyc, hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones, pm, sec_pulse, day_pulse,
                     e.cyc, e.ht, e.ho, e.mt, e.mo, e.st, e.so, e.pm, e.sp, e.dp);
        end
    endtask

    // Pulse monitor: every sec_pulse must match the next expected update
    always @(negedge clk) begin
        if (sec_pulse) begin
            if (pulse_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_sec_pulse cyc=%0d got %0d%0d:%0d%0d:%0d%0d want no pulse",
                         cyc, hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones);
            end else begin
                mon_e = pulse_q.pop_front();
                compare(mon_e, 1'b1);
            end
        end else if (day_pulse) begin
            checks++;
            errors++;
            $display("FAIL lone_day_pulse cyc=%0d got day_pulse=1 want 0", cyc);
        end
    end

    // Snapshot monitor for requested static checks
    always @(probe_ev) begin
        if (probe_q.size() != 0) begin
            prb_e = probe_q.pop_front();
            compare(prb_e, 1'b0);
        end
    end

    task automatic probe(input string name, input int h, input int m, input int s,
                         input logic mode, input logic sp, input logic dp);
        probe_q.push_back(mk(name, h, m, s, mode, sp, dp, 0));
        -> probe_ev;
        #0;
    endtask

    // Expected 24 h updates for n ticks after a count base
    task automatic push_run(input string name, input int h, input int m, input int s,
                            input int n, input int b);
        int t;
        for (int k = 1; k <= n; k++) begin
            t = (h * 3600 + m * 60 + s + k) % 86400;
            pulse_q.push_back(mk(name, t / 3600, (t / 60) % 60, t % 60, 1'b1, 1'b1, (t == 0), b + 4 * k + 1));
        end
    endtask

    // Load a time; base is the load edge, returns once the display shows it
    task automatic do_set(input int h, input int m);
        set_hour = 5'(h);
        set_min  = 6'(m);
        set_en   = 1'b1;
        @(posedge clk); #1;
        set_en = 1'b0;
        base   = cyc;
        @(posedge clk); #1;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; set_en = 1'b0; mode_24h = 1'b1;
        set_hour = '0; set_min = '0;
        step(2);
        probe("reset", 0, 0, 0, 1'b1, 1'b0, 1'b0);

        // Count from reset
        run = 1'b1;
        rst = 1'b0;
        base = cyc;
        push_run("count", 0, 0, 0, 60, base);
        step(241);
        probe("count_1min", 0, 1, 0, 1'b1, 1'b1, 1'b0);

        // Day rollover
        do_set(23, 59);
        probe("set_2359", 23, 59, 0, 1'b1, 1'b0, 1'b0);
        push_run("rollover", 23, 59, 0, 60, base);
        step(240);
        probe("day_end", 0, 0, 0, 1'b1, 1'b1, 1'b1);

        // 12 h mapping with the prescaler held
        run = 1'b0;
        mode_24h = 1'b0;
        do_set(0, 5);
        probe("h12_hour0", 0, 5, 0, 1'b0, 1'b0, 1'b0);
        do_set(11, 30);
        probe("h12_hour11", 11, 30, 0, 1'b0, 1'b0, 1'b0);
        do_set(12, 0);
        probe("h12_hour12", 12, 0, 0, 1'b0, 1'b0, 1'b0);
        do_set(13, 45);
        probe("h12_hour13", 13, 45, 0, 1'b0, 1'b0, 1'b0);
        mode_24h = 1'b1;
        probe("mode_latency", 13, 45, 0, 1'b0, 1'b0, 1'b0);
        step(1);
        probe("mode_24_hour13", 13, 45, 0, 1'b1, 1'b0, 1'b0);

        // Clamped set coinciding with a tick
        run = 1'b1;
        do_set(1, 2);
        step(2);
        do_set(30, 63);
        probe("clamp", 23, 59, 0, 1'b1, 1'b0, 1'b0);
        pulse_q.push_back(mk("after_clamp", 23, 59, 1, 1'b1, 1'b1, 1'b0, base + 5));

        // Run hold at prescaler 2
        step(5);
        run = 1'b0;
        step(10);
        run = 1'b1;
        pulse_q.push_back(mk("after_hold", 23, 59, 2, 1'b1, 1'b1, 1'b0, base + 19));
        step(3);

        // Asynchronous reset while 12:34:56 and its pulse are showing
        do_set(12, 34);
        push_run("to_123456", 12, 34, 0, 56, base);
        step(224);
        #5;
        rst = 1'b1;
        #1;
        probe("async_rst", 0, 0, 0, 1'b1, 1'b0, 1'b0);
        step(3);
        rst = 1'b0;
        base = cyc;
        push_run("restart", 0, 0, 0, 3, base);
        step(13);
        run = 1'b0;
        step(8);

        // Expected updates that never appeared
        while (pulse_q.size() != 0) begin
            mon_e = pulse_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_pulse %s got none want cyc=%0d", mon_e.name, mon_e.cyc);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
